// File: rtl/alu_issue_capture_if.sv
// alu_issue_capture_if: request/result handshake between the control unit and the ALU issue stage.
interface alu_issue_capture_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_ctrl;
    logic             op_inc_pc;
    logic             done_ack;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             zero_flag;
    logic             neg_flag;
    logic             illegal_op;
    logic             div0;
    modport master (
        output start, op_a, op_b, op_ctrl, op_inc_pc, done_ack,
        input  busy, done, z_reg, hi_reg, lo_reg, zero_flag, neg_flag, illegal_op, div0
    );
    modport slave (
        input  start, op_a, op_b, op_ctrl, op_inc_pc, done_ack,
        output busy, done, z_reg, hi_reg, lo_reg, zero_flag, neg_flag, illegal_op, div0
    );
endinterface

// File: rtl/alu_issue_capture.sv
// alu_issue_capture: holds ALU operands for SETTLE cycles, then captures results into Z/HI/LO with a done/done_ack handshake.
// Optional macro ALU_DIV0_TRAP_EN short-circuits divide-by-zero straight to DONE with div0 raised.
module alu_issue_capture #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2
) (
    input  logic              Clk,
    input  logic              Clr,
    alu_issue_capture_if.slave req,
    output logic [WIDTH-1:0]  alu_reg1,
    output logic [WIDTH-1:0]  alu_reg2,
    output logic [3:0]        alu_control,
    output logic              alu_inc_pc,
    input  logic [WIDTH-1:0]  z_Output1,
    input  logic [WIDTH-1:0]  z_Output2
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       accept, ack, trap, capture, z_wr, wide, illegal;
    assign ack     = state == DONE && req.done_ack;
    assign accept  = req.start && (state == IDLE || ack);
    assign capture = state == CAPTURE;
    // Decode uses the latched op, not the live request, which may already have moved on.
    assign z_wr    = alu_inc_pc || alu_control <= 4'd11;
    assign wide    = !alu_inc_pc && alu_control <= 4'd1;
    assign illegal = !alu_inc_pc && alu_control > 4'd11;
`ifdef ALU_DIV0_TRAP_EN
    assign trap = accept && req.op_ctrl == 4'd0 && !req.op_inc_pc && req.op_b == '0;
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) req.div0 <= 1'b0;
        else      req.div0 <= trap ? 1'b1 : ack ? 1'b0 : req.div0;
    end
`else
    assign trap     = 1'b0;
    assign req.div0 = 1'b0;
`endif
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) state <= IDLE;
        else      state <= state_nxt;
    end
    always_comb begin
        state_nxt = accept ? (trap ? DONE : ISSUE) :
                    state == ISSUE ? (cnt == '0 ? CAPTURE : ISSUE) :
                    state == CAPTURE ? DONE :
                    ack ? IDLE : state;
    end
    always_comb begin
        req.busy = state != IDLE;
        req.done = state == DONE;
    end
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            cnt            <= '0;
            alu_reg1       <= '0;
            alu_reg2       <= '0;
            alu_control    <= '0;
            alu_inc_pc     <= 1'b0;
            req.z_reg      <= '0;
            req.hi_reg     <= '0;
            req.lo_reg     <= '0;
            req.zero_flag  <= 1'b0;
            req.neg_flag   <= 1'b0;
            req.illegal_op <= 1'b0;
        end else begin
            cnt <= accept ? 4'(SETTLE - 1) : (state == ISSUE && cnt != '0) ? cnt - 4'd1 : cnt;
            if (accept) begin
                alu_reg1    <= req.op_a;
                alu_reg2    <= req.op_b;
                alu_control <= req.op_ctrl;
                alu_inc_pc  <= req.op_inc_pc;
            end
            if (capture && z_wr) begin
                req.z_reg     <= z_Output1;
                req.zero_flag <= z_Output1 == '0;
                req.neg_flag  <= z_Output1[WIDTH-1];
            end
            if (capture && wide) begin
                req.lo_reg <= z_Output1;
                req.hi_reg <= z_Output2;
            end
            req.illegal_op <= capture ? illegal : ack ? 1'b0 : req.illegal_op;
        end
    end
endmodule

// File: tb/tb_alu_issue_capture.sv
// tb_alu_issue_capture: directed ops with a behavioural ALU; a monitor scores each done against queued expectations.
module tb_alu_issue_capture;
    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [31:0] alu_reg1, alu_reg2, z1, z2;
    logic [3:0]  alu_control;
    logic        alu_inc_pc;
    logic [63:0] prod;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    typedef struct {
        logic [31:0] z, hi, lo;
        logic        zf, nf, ill, d0;
        int          lat, c;
    } exp_t;
    exp_t sb[$];
    alu_issue_capture_if #(.WIDTH(32)) bus();
    alu_issue_capture #(.WIDTH(32), .SETTLE(2)) dut (
        .Clk(clk), .Clr(clr_n), .req(bus),
        .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_control(alu_control), .alu_inc_pc(alu_inc_pc),
        .z_Output1(z1), .z_Output2(z2)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb begin
        prod = 64'(alu_reg1) * 64'(alu_reg2);
        z1 = alu_reg1 | alu_reg2;
        z2 = 32'd0;
        if (alu_inc_pc) z1 = alu_reg2 + 32'd1;
        else case (alu_control)
            4'd0: if (alu_reg2 == 0) begin z1 = '1; z2 = alu_reg1; end
                  else begin z1 = alu_reg1 / alu_reg2; z2 = alu_reg1 % alu_reg2; end
            4'd1: {z2, z1} = prod;
            4'd2: z1 = alu_reg1 + alu_reg2;
            4'd3: z1 = alu_reg1 - alu_reg2;
            4'd4: z1 = alu_reg1 & alu_reg2;
            default: ;
        endcase
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    initial begin : monitor
        logic pd;
        exp_t e;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done && !pd) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - e.c), 32'(e.lat));
                    chk("z_reg", bus.z_reg, e.z);
                    chk("hi_reg", bus.hi_reg, e.hi);
                    chk("lo_reg", bus.lo_reg, e.lo);
                    chk("zero_flag", 32'(bus.zero_flag), 32'(e.zf));
                    chk("neg_flag", 32'(bus.neg_flag), 32'(e.nf));
                    chk("illegal_op", 32'(bus.illegal_op), 32'(e.ill));
                    chk("div0", 32'(bus.div0), 32'(e.d0));
                    chk("busy_in_done", 32'(bus.busy), 32'd1);
                end
            end
            pd = bus.done;
        end
    end
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                          input logic inc, input exp_t e);
        int n;
        @(negedge clk);
        bus.op_a = a; bus.op_b = b; bus.op_ctrl = ctrl; bus.op_inc_pc = inc;
        bus.start = 1'b1;
        bus.done_ack = bus.done;
        e.c = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.done_ack = 1'b0;
        bus.op_a = ~a; bus.op_b = ~b; bus.op_ctrl = ctrl ^ 4'hA; bus.op_inc_pc = ~inc;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(bus.done), 32'd1);
    endtask
    task automatic do_ack();
        @(negedge clk);
        bus.done_ack = 1'b1;
        @(negedge clk);
        bus.done_ack = 1'b0;
        chk("ack_done", 32'(bus.done), 32'd0);
        chk("ack_busy", 32'(bus.busy), 32'd0);
    endtask
    initial begin : stim
        bus.start = 1'b0; bus.done_ack = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.op_ctrl = '0; bus.op_inc_pc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_z", bus.z_reg, 32'd0);
        chk("rst_hi", bus.hi_reg, 32'd0);
        chk("rst_lo", bus.lo_reg, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_flags", {28'd0, bus.zero_flag, bus.neg_flag, bus.illegal_op, bus.div0}, 32'd0);
        clr_n = 1'b1;
        run_op(32'd5, 32'd7, 4'd2, 1'b0, '{32'd12, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0});
        do_ack();
        run_op(32'h0001_0000, 32'h0001_0000, 4'd1, 1'b0, '{32'd0, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0});
        run_op(32'd100, 32'd7, 4'd0, 1'b0, '{32'd14, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0});
        run_op(32'd3, 32'hFFFF_FFFF, 4'd5, 1'b1, '{32'd0, 32'd2, 32'd14, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0});
        run_op(32'd3, 32'd5, 4'd3, 1'b0, '{32'hFFFF_FFFE, 32'd2, 32'd14, 1'b0, 1'b1, 1'b0, 1'b0, 4, 0});
        run_op(32'd1, 32'd2, 4'd13, 1'b0, '{32'hFFFF_FFFE, 32'd2, 32'd14, 1'b0, 1'b1, 1'b1, 1'b0, 4, 0});
        do_ack();
        chk("illegal_cleared", 32'(bus.illegal_op), 32'd0);
`ifdef ALU_DIV0_TRAP_EN
        run_op(32'd9, 32'd0, 4'd0, 1'b0, '{32'hFFFF_FFFE, 32'd2, 32'd14, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0});
`else
        run_op(32'd9, 32'd0, 4'd0, 1'b0, '{32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 4, 0});
`endif
        do_ack();
        chk("div0_cleared", 32'(bus.div0), 32'd0);
        chk("alu_reg1_held", alu_reg1, 32'd9);
        @(negedge clk);
        bus.op_a = 32'd1; bus.op_b = 32'd1; bus.op_ctrl = 4'd2; bus.op_inc_pc = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        clr_n = 1'b0;
        #1;
        chk("abort_z", bus.z_reg, 32'd0);
        chk("abort_hilo", bus.hi_reg | bus.lo_reg, 32'd0);
        chk("abort_alu_reg1", alu_reg1, 32'd0);
        chk("abort_state", {28'd0, bus.busy, bus.done, bus.zero_flag, bus.neg_flag}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_done", {30'd0, bus.busy, bus.done}, 32'd0);
        run_op(32'h0000_F0F0, 32'h0000_FF00, 4'd4, 1'b0, '{32'h0000_F000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0});
        do_ack();
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100000");
        $fatal(1, "watchdog expired");
    end
endmodule
